// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D-cache to RAM arbiter: RAM handshake state,
// the word type and the arbiter's grant states.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } arb_state_t;

  localparam int unsigned STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signals of the memory arbiter, bundled.
// master = the arbiter's view, slave = the surrounding caches/RAM.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // icache side
  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      iwait;
  // dcache side
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dwait;
  // RAM side
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates I- and D-cache word requests onto one RAM port. D has priority;
// a streak counter forces an I grant after STARVE_MAX D grants while I waits.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input logic           CLK,
  input logic           nRST,
  mem_arbiter_if.master bus
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STREAK_SAT = SW'(STARVE_MAX);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic [SW-1:0] r_streak;
  logic [SW-1:0] w_streak_nxt;

  logic          w_dreq;
  logic          w_access;
  logic [SW-1:0] w_streak_inc;

  assign w_dreq       = bus.dREN | bus.dWEN;
  assign w_access     = (bus.ramstate == ACCESS);
  assign w_streak_inc = (r_streak == STREAK_SAT) ? STREAK_SAT : r_streak + 1'b1;

  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_streak <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;

    unique case (r_state)
      IDLE: begin
        if (w_dreq && bus.iREN)
          w_state_nxt = (r_streak == STREAK_SAT) ? IGNT : DGNT;
        else if (w_dreq)
          w_state_nxt = DGNT;
        else if (bus.iREN)
          w_state_nxt = IGNT;
      end

      DGNT: begin
        // A withdrawn request releases the port without a completion pulse.
        if (!w_dreq) begin
          w_state_nxt = IDLE;
        end else begin
          bus.ramWEN   = bus.dWEN;
          bus.ramREN   = bus.dREN & ~bus.dWEN;
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          bus.dwait    = ~w_access;
          if (w_access) begin
            w_state_nxt  = IDLE;
            w_streak_nxt = bus.iREN ? w_streak_inc : '0;
          end
        end
      end

      IGNT: begin
        if (!bus.iREN) begin
          w_state_nxt = IDLE;
        end else begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr;
          bus.iwait   = ~w_access;
          if (w_access) begin
            w_state_nxt  = IDLE;
            w_streak_nxt = '0;
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned SMAX = 4;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: who currently owns the port (0 none, 1 D, 2 I) and how many D
  // words have finished back-to-back while I kept asking.
  int owner  = 0;
  int d_run  = 0;
  int grants[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Outputs are compared at the falling edge against the model.
  task automatic chk();
    logic  e_ren, e_wen, e_iw, e_dw, acc;
    word_t e_addr, e_st;
    @(negedge CLK);
    if (!nRST) begin owner = 0; d_run = 0; end
    e_ren = 1'b0; e_wen = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
    e_addr = '0; e_st = '0;
    acc = (bus.ramstate == ACCESS);
    if (owner == 1 && (bus.dREN || bus.dWEN)) begin
      e_wen  = bus.dWEN;
      e_ren  = bus.dREN && !bus.dWEN;
      e_addr = bus.daddr;
      e_st   = bus.dstore;
      e_dw   = !acc;
    end
    if (owner == 2 && bus.iREN) begin
      e_ren  = 1'b1;
      e_addr = bus.iaddr;
      e_iw   = !acc;
    end
    check("ramREN",   bus.ramREN,   e_ren);
    check("ramWEN",   bus.ramWEN,   e_wen);
    check("ramaddr",  bus.ramaddr,  e_addr);
    check("ramstore", bus.ramstore, e_st);
    check("iwait",    bus.iwait,    e_iw);
    check("dwait",    bus.dwait,    e_dw);
    check("iload",    bus.iload,    bus.ramload);
    check("dload",    bus.dload,    bus.ramload);
  endtask

  // Rising edge: advance the model by one cycle of the arbitration rules.
  task automatic adv();
    logic dq, acc;
    @(posedge CLK);
    dq  = bus.dREN || bus.dWEN;
    acc = (bus.ramstate == ACCESS);
    if (!nRST) begin
      owner = 0; d_run = 0;
    end else if (owner == 0) begin
      if (dq && bus.iREN) owner = (d_run >= SMAX) ? 2 : 1;
      else if (dq)        owner = 1;
      else if (bus.iREN)  owner = 2;
      if (owner != 0) grants.push_back(owner);
    end else if (owner == 1) begin
      if (!dq) owner = 0;
      else if (acc) begin
        owner = 0;
        d_run = bus.iREN ? ((d_run + 1 > SMAX) ? SMAX : d_run + 1) : 0;
      end
    end else begin
      if (!bus.iREN) owner = 0;
      else if (acc) begin owner = 0; d_run = 0; end
    end
    #1;
  endtask

  task automatic cyc();
    chk();
    adv();
  endtask

  task automatic clear_inputs();
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = '0; bus.ramstate = FREE;
  endtask

  task automatic check_order(input string name, input int exp[]);
    check({name, " count"}, grants.size() >= exp.size(), 1);
    for (int i = 0; i < exp.size() && i < grants.size(); i++)
      check(name, grants[i], exp[i]);
  endtask

  initial begin
    int order_a[];
    int order_b[];
    int r;
    order_a = '{1, 1, 1, 1, 2, 1};
    order_b = '{1, 1, 1, 1, 2};

    // 1: reset held with both requests high
    clear_inputs();
    bus.iREN = 1'b1; bus.dREN = 1'b1;
    #2;
    chk();
    check("t1 ramREN", bus.ramREN, 0);
    check("t1 ramWEN", bus.ramWEN, 0);
    check("t1 iwait",  bus.iwait,  1);
    check("t1 dwait",  bus.dwait,  1);
    adv();
    clear_inputs();
    nRST = 1'b1;

    // 2: single I read, two BUSY cycles then ACCESS
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
    cyc();
    chk();
    check("t2 ramaddr", bus.ramaddr, 32'h40);
    check("t2 ramREN",  bus.ramREN,  1);
    check("t2 iwait busy", bus.iwait, 1);
    adv();
    cyc();
    bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
    chk();
    check("t2 iwait", bus.iwait, 0);
    check("t2 iload", bus.iload, 32'hDEADBEEF);
    check("t2 dwait", bus.dwait, 1);
    adv();
    clear_inputs();

    // 3: D writeback beats a pending I read
    bus.dWEN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
    bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.ramstate = ACCESS;
    cyc();
    chk();
    check("t3 ramWEN",   bus.ramWEN,   1);
    check("t3 ramREN",   bus.ramREN,   0);
    check("t3 ramstore", bus.ramstore, 32'h1234);
    check("t3 ramaddr",  bus.ramaddr,  32'h80);
    check("t3 dwait",    bus.dwait,    0);
    adv();
    bus.dWEN = 1'b0; bus.dREN = 1'b0;
    cyc();
    chk();
    check("t3 i ramaddr", bus.ramaddr, 32'h44);
    check("t3 i iwait",   bus.iwait,   0);
    adv();
    clear_inputs();

    // 4: D and I both saturating, every access completes at once
    grants.delete();
    bus.dREN = 1'b1; bus.daddr = 32'h200; bus.iREN = 1'b1; bus.iaddr = 32'h300;
    bus.ramstate = ACCESS;
    repeat (12) cyc();
    check_order("t4 grant", order_a);
    clear_inputs();
    cyc();

    // 5: ERROR retries, then a withdrawn request mid-BUSY
    bus.dREN = 1'b1; bus.daddr = 32'h100; bus.ramstate = ERROR;
    cyc();
    repeat (3) begin
      chk();
      check("t5 dwait err",  bus.dwait,  1);
      check("t5 ramREN err", bus.ramREN, 1);
      adv();
    end
    bus.ramstate = ACCESS;
    chk();
    check("t5 dwait done", bus.dwait, 0);
    adv();
    bus.ramstate = BUSY;
    cyc();
    cyc();
    bus.dREN = 1'b0;
    chk();
    check("t5 drop ramREN", bus.ramREN, 0);
    check("t5 drop dwait",  bus.dwait,  1);
    adv();
    cyc();
    clear_inputs();

    // 6: reset in the middle of an I grant clears the streak
    bus.dREN = 1'b1; bus.daddr = 32'h500; bus.iREN = 1'b1; bus.iaddr = 32'h600;
    bus.ramstate = ACCESS;
    repeat (4) cyc();
    bus.dREN = 1'b0; bus.ramstate = BUSY;
    cyc();
    chk();
    check("t6 ramREN ignt", bus.ramREN,  1);
    check("t6 addr ignt",   bus.ramaddr, 32'h600);
    nRST = 1'b0;
    #1;
    check("t6 async ramREN", bus.ramREN, 0);
    check("t6 async iwait",  bus.iwait,  1);
    adv();
    nRST = 1'b1;
    bus.dREN = 1'b1; bus.ramstate = ACCESS;
    grants.delete();
    repeat (10) cyc();
    check_order("t6 grant", order_b);
    clear_inputs();
    cyc();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      nRST = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 9) == 0) bus.iREN = ~bus.iREN;
      if ($urandom_range(0, 9) == 0) bus.dREN = ~bus.dREN;
      if ($urandom_range(0, 11) == 0) bus.dWEN = ~bus.dWEN;
      if ($urandom_range(0, 3) == 0) bus.iaddr = $urandom;
      if ($urandom_range(0, 3) == 0) bus.daddr = $urandom;
      bus.dstore  = $urandom;
      bus.ramload = $urandom;
      r = $urandom_range(0, 99);
      bus.ramstate = (r < 30) ? ACCESS : (r < 70) ? BUSY : (r < 85) ? FREE : ERROR;
      chk();
      check("both waits", bus.iwait | bus.dwait, 1);
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
